frame_admit_ctrl: RTL

- Frame-level scheduler between the TMDS token/sync extraction and the MJPG encoder.
- Decides at every frame boundary (vsync rising edge) whether the next frame is forwarded to the encoder.
- Decision inputs: a programmable decimation ratio, an enable, and backpressure from the encoder and the encoder-to-Ethernet bridge.
- Forwards pvalid/vsync/ycbcr with one registered stage and keeps frame statistics for debug.

---
 rtl/frame_admit_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/frame_admit_ctrl.sv
// Frame admission gate between sync extraction and the MJPG encoder.
// Decides per vsync rising edge whether a frame is forwarded; keeps debug statistics.
module frame_admit_ctrl #(
    parameter int DATA_W  = 24,
    parameter int DECIM_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DECIM_W-1:0] decim,
    input  logic              clr_stats,
    input  logic              pvalid_in,
    input  logic              vsync_in,
    input  logic [DATA_W-1:0] ycbcr_in,
    input  logic              enc_busy,
    input  logic              q_afull,
    input  logic              q_full,
    output logic              pvalid_out,
    output logic              vsync_out,
    output logic [DATA_W-1:0] ycbcr_out,
    output logic              frame_active,
    output logic [CNT_W-1:0]  frames_in,
    output logic [CNT_W-1:0]  frames_sent,
    output logic [CNT_W-1:0]  frames_busy_drop,
    output logic              ovf
);

    typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_SKIP} state_t;

    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [DECIM_W-1:0] PH_ONE  = DECIM_W'(1);

    state_t              r_state;
    logic                r_vsync_d;
    logic [DECIM_W-1:0]  r_ph;
    logic                r_pvalid_out;
    logic                r_vsync_out;
    logic [DATA_W-1:0]   r_ycbcr_out;
    logic                r_frame_active;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_cnt [3];

    logic                w_bnd;
    logic                w_ph_zero;
    logic                w_admit;
    logic                w_blocked;
    logic                w_pass_now;
    logic [DECIM_W-1:0]  w_ph_next;
    logic [2:0]          w_inc;

    assign w_bnd      = vsync_in & ~r_vsync_d;
    assign w_ph_zero  = (r_ph == '0);
    assign w_admit    = enable & w_ph_zero & ~enc_busy & ~q_afull;
    assign w_blocked  = enable & w_ph_zero & (enc_busy | q_afull);
    assign w_pass_now = w_bnd ? w_admit : (r_state == ST_PASS);
    assign w_ph_next  = (r_ph >= decim) ? '0 : r_ph + PH_ONE;

    // Counter order: frames_in, frames_sent, frames_busy_drop
    assign w_inc = {w_bnd & w_blocked, w_bnd & w_admit, w_bnd};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_vsync_d      <= 1'b0;
            r_ph           <= '0;
            r_pvalid_out   <= 1'b0;
            r_vsync_out    <= 1'b0;
            r_ycbcr_out    <= '0;
            r_frame_active <= 1'b0;
            r_ovf          <= 1'b0;
        end else begin
            r_vsync_d      <= vsync_in;
            r_pvalid_out   <= pvalid_in & w_pass_now;
            r_vsync_out    <= vsync_in & w_pass_now;
            r_ycbcr_out    <= ycbcr_in;
            r_frame_active <= w_pass_now;
            if (w_bnd) begin
                r_ph    <= w_ph_next;
                r_state <= w_admit ? ST_PASS : ST_SKIP;
            end
            // Clear has priority over a coincident overflow event
            if (clr_stats)
                r_ovf <= 1'b0;
            else if (q_full & r_pvalid_out)
                r_ovf <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_ff @(posedge clk) begin
                if (rst || clr_stats)
                    r_cnt[gi] <= '0;
                else if (w_inc[gi])
                    r_cnt[gi] <= r_cnt[gi] + CNT_ONE;
            end
        end
    endgenerate

    assign pvalid_out       = r_pvalid_out;
    assign vsync_out        = r_vsync_out;
    assign ycbcr_out        = r_ycbcr_out;
    assign frame_active     = r_frame_active;
    assign ovf              = r_ovf;
    assign frames_in        = r_cnt[0];
    assign frames_sent      = r_cnt[1];
    assign frames_busy_drop = r_cnt[2];

endmodule
